// File: rtl/avmm_host_bridge_pkg.sv
// Shared types and constants for the Avalon-MM host bridge.
package avmm_host_bridge_pkg;

  localparam int unsigned MID_W  = 2;
  localparam int unsigned VID_W  = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 16;

  // Control variable ids understood by the program-logic slave
  localparam logic [VID_W-1:0] APPLY_UPDATES = 12'd9;
  localparam logic [VID_W-1:0] DROP_UPDATES  = 12'd10;
  localparam logic [VID_W-1:0] CONTINUE      = 12'd12;
  localparam logic [VID_W-1:0] RESET         = 12'd13;
  localparam logic [VID_W-1:0] OPEN_LOOP     = 12'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } state_e;

  typedef struct packed {
    logic              write;
    logic [MID_W-1:0]  mid;
    logic [VID_W-1:0]  vid;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic logic [ADDR_W-1:0] make_addr(input logic [MID_W-1:0] mid,
                                                  input logic [VID_W-1:0] vid);
    return {{(ADDR_W - MID_W - VID_W){1'b0}}, mid, vid};
  endfunction

endpackage

// File: rtl/avmm_host_bridge_timer.sv
// Loadable, zero-saturating down-counter used for both the idle gap and the transfer timeout.
module avmm_host_bridge_timer
  import avmm_host_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/avmm_host_bridge.sv
// Host command stream to single Avalon-MM transfer, with forced idle gap and timeout.
// Define AVMM_HOST_BRIDGE_STATS_EN to add transfer/timeout/wait statistics outputs.
module avmm_host_bridge
  import avmm_host_bridge_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [MID_W-1:0]  cmd_mid,
  input  logic [VID_W-1:0]  cmd_vid,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
`ifdef AVMM_HOST_BRIDGE_STATS_EN
  output logic [31:0]       stat_xfers,
  output logic [15:0]       stat_timeouts,
  output logic [31:0]       stat_wait,
`endif
  input  logic              m_waitrequest
);

  localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              first_q, first_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [DATA_W-1:0] m_writedata_q, m_writedata_d;
  logic              tmr_load, tmr_dec;
  logic [CNT_W-1:0]  tmr_val, tmr_cnt;
  cmd_t              cmd_in;

  assign cmd_in = {cmd_write, cmd_mid, cmd_vid, cmd_data};

  avmm_host_bridge_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .cnt_o      (tmr_cnt)
  );

  always_comb begin
    state_d       = state_q;
    first_d       = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_error_d   = rsp_error_q;
    rsp_data_d    = rsp_data_q;
    m_read_d      = m_read_q;
    m_write_d     = m_write_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    tmr_load      = 1'b0;
    tmr_dec       = 1'b0;
    tmr_val       = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          m_read_d      = !cmd_in.write;
          m_write_d     = cmd_in.write;
          m_address_d   = make_addr(cmd_in.mid, cmd_in.vid);
          m_writedata_d = cmd_in.write ? cmd_in.data : '0;
          tmr_load      = 1'b1;
          tmr_val       = CNT_W'(TIMEOUT_CYCLES);
          first_d       = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        tmr_dec = 1'b1;
        // First ISSUE cycle still sees the slave's idle waitrequest, so skip it
        if (!first_q && !m_waitrequest) begin
          rsp_data_d  = m_read_q ? m_readdata : '0;
          rsp_error_d = 1'b0;
          rsp_valid_d = 1'b1;
          m_read_d    = 1'b0;
          m_write_d   = 1'b0;
          state_d     = RESP;
        end else if (TMO_EN && (tmr_cnt == CNT_W'(1))) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          m_read_d    = 1'b0;
          m_write_d   = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = CNT_W'(GAP_CYCLES);
          state_d     = GAP;
        end
      end
      GAP: begin
        tmr_dec = 1'b1;
        if (tmr_cnt <= CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      first_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_data_q    <= '0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      first_q       <= first_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_data_q    <= rsp_data_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_data    = rsp_data_q;
  assign m_read      = m_read_q;
  assign m_write     = m_write_q;
  assign m_address   = m_address_q;
  assign m_writedata = m_writedata_q;

`ifdef AVMM_HOST_BRIDGE_STATS_EN
  logic        xfer_done, xfer_tmo;
  logic [31:0] xfers_q, wait_q;
  logic [15:0] tmos_q;

  assign xfer_done = (state_q == ISSUE) && (state_d == RESP) && !rsp_error_d;
  assign xfer_tmo  = (state_q == ISSUE) && (state_d == RESP) && rsp_error_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      xfers_q <= '0;
      tmos_q  <= '0;
      wait_q  <= '0;
    end else begin
      if (xfer_done) xfers_q <= xfers_q + 32'd1;
      if (xfer_tmo) tmos_q <= tmos_q + 16'd1;
      if (state_q == ISSUE) wait_q <= wait_q + 32'd1;
    end
  end

  assign stat_xfers    = xfers_q;
  assign stat_timeouts = tmos_q;
  assign stat_wait     = wait_q;
`endif

endmodule

// File: tb/tb_avmm_host_bridge.sv
// Scoreboard bench for avmm_host_bridge: random commands against a command-level model and a behavioural slave.
module tb_avmm_host_bridge;

  localparam int unsigned GAP = 1;
  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_mid = 2'd0;
  logic [11:0] cmd_vid = 12'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [15:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  always #5 clk = ~clk;

  avmm_host_bridge #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_mid       (cmd_mid),
    .cmd_vid       (cmd_vid),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_error     (rsp_error),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          hold;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t rsp_q[$];
  exp_t xfer_q[$];
  int   dly_q[$];

  int checks = 0;
  int errors = 0;
  int writes_issued = 0;
  logic mon_en = 1'b1;
  logic stall_req = 1'b0;
  logic stalled = 1'b0;

  // Reference contents of the slave's variable space, per {mid,vid}
  logic [31:0] model_mem [16384] = '{16: 32'h21, default: 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- behavioural slave ----------------
  logic [31:0] slv_mem [16384] = '{16: 32'h21, default: 32'h0};
  int   slv_cnt = 0;
  int   slv_delay = 0;
  int   wr_edges = 0;
  logic slv_wr_prev = 1'b0;

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready && reset) begin
      if (dly_q.size() > 0) slv_delay <= dly_q.pop_front();
      else slv_delay <= 0;
    end
    slv_cnt     <= (m_read || m_write) ? slv_cnt + 1 : 0;
    slv_wr_prev <= m_write;
    if (m_write && !slv_wr_prev) begin
      wr_edges <= wr_edges + 1;
      if (m_address[13:12] != 2'd3) slv_mem[m_address[13:0]] <= m_writedata;
    end
  end

  // Waitrequest stays high for the first slv_delay cycles of each transfer
  assign m_waitrequest = !(m_read || m_write) || (slv_cnt < slv_delay);
  assign m_readdata = (m_read && (m_address[13:12] != 2'd3)) ? slv_mem[m_address[13:0]] : 32'd0;

  // ---------------- response consumer ----------------
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req && !stalled && rsp_valid) begin
        rsp_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        stalled = 1'b1;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- Avalon-side monitor ----------------
  logic xm_prev = 1'b0;
  logic xm_seen = 1'b0;
  int   xm_run = 0;
  int   xm_gap = 0;
  exp_t xm_cur;

  initial begin
    logic act;
    xm_cur = '{data: 32'h0, err: 1'b0, hold: 0, wr: 1'b0, addr: 16'h0, wdata: 32'h0};
    forever begin
      @(negedge clk);
      act = m_read || m_write;
      if (!reset || !mon_en) begin
        xm_prev = 1'b0;
        xm_seen = 1'b0;
      end else begin
        chk("rd_wr_exclusive", 32'(m_read && m_write), 32'(0));
        if (act && !xm_prev) begin
          if (xfer_q.size() == 0) flag("unexpected_xfer");
          else xm_cur = xfer_q.pop_front();
          if (xm_seen) chk("idle_gap_long_enough", 32'(xm_gap >= int'(GAP) + 2), 32'(1));
          xm_run = 0;
        end
        if (act) begin
          xm_run++;
          chk("m_address", 32'(m_address), 32'(xm_cur.addr));
          chk("m_write_kind", 32'(m_write), 32'(xm_cur.wr));
          if (xm_cur.wr) chk("m_writedata", m_writedata, xm_cur.wdata);
        end else if (xm_prev) begin
          chk("hold_cycles", 32'(xm_run), 32'(xm_cur.hold));
          chk("rsp_valid_after_xfer", 32'(rsp_valid), 32'(1));
          xm_seen = 1'b1;
          xm_gap = 1;
        end else begin
          xm_gap++;
        end
        xm_prev = act;
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  logic        rm_pv = 1'b0;
  logic        rm_pr = 1'b0;
  logic        rm_pe = 1'b0;
  logic [31:0] rm_pd = 32'h0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rm_pv = 1'b0;
      end else begin
        if (rm_pv && !rm_pr) begin
          chk("rsp_valid_held", 32'(rsp_valid), 32'(1));
          chk("rsp_data_held", rsp_data, rm_pd);
          chk("rsp_error_held", 32'(rsp_error), 32'(rm_pe));
        end
        if (rsp_valid) chk("cmd_ready_while_rsp", 32'(cmd_ready), 32'(0));
        if (rsp_valid && rsp_ready) begin
          if (rsp_q.size() == 0) begin
            flag("unexpected_rsp");
          end else begin
            e = rsp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_error", 32'(rsp_error), 32'(e.err));
          end
        end
        rm_pv = rsp_valid;
        rm_pr = rsp_ready;
        rm_pd = rsp_data;
        rm_pe = rsp_error;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic wr, input logic [1:0] mid, input logic [11:0] vid,
                       input logic [31:0] data, input int d);
    exp_t e;
    int   kc;
    int   guard;
    logic [13:0] a;
    a = {mid, vid};
    // Transfer ends at the first sampled (2nd or later) ISSUE cycle with waitrequest low
    kc = (d + 1 < 2) ? 2 : d + 1;
    e.addr  = {2'b00, mid, vid};
    e.wr    = wr;
    e.wdata = data;
    if (kc <= int'(TMO)) begin
      e.err  = 1'b0;
      e.hold = kc;
      e.data = (wr || mid == 2'd3) ? 32'd0 : model_mem[a];
    end else begin
      e.err  = 1'b1;
      e.hold = int'(TMO);
      e.data = 32'd0;
    end
    if (wr && mid != 2'd3) model_mem[a] = data;
    if (wr) writes_issued++;
    rsp_q.push_back(e);
    xfer_q.push_back(e);
    dly_q.push_back(d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_mid   = mid;
    cmd_vid   = vid;
    cmd_data  = data;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!cmd_ready && guard < 300);
    if (!cmd_ready) flag("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("issue_start_write", 32'(m_write), 32'(wr));
    chk("issue_start_read", 32'(m_read), 32'(!wr));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (rsp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (rsp_q.size() != 0) flag("drain_timeout");
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [11:0] vid_tab [7] = '{12'd5, 12'd9, 12'd10, 12'd12, 12'd13, 12'd15, 12'd16};

  initial begin
    int d;
    int guard;
    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_rsp_data", rsp_data, 32'(0));
    chk("reset_rsp_error", 32'(rsp_error), 32'(0));
    chk("reset_m_read", 32'(m_read), 32'(0));
    chk("reset_m_write", 32'(m_write), 32'(0));
    chk("reset_m_address", 32'(m_address), 32'(0));
    chk("reset_m_writedata", m_writedata, 32'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("cmd_ready_reset_cycle", 32'(cmd_ready), 32'(0));
    @(posedge clk);
    #1;
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'(1));

    // directed: write, read of preloaded value, back-to-back writes, timeout
    issue(1'b1, 2'd0, 12'd5, 32'h0000_002A, 2);
    issue(1'b0, 2'd0, 12'd16, 32'h0, 2);
    issue(1'b1, 2'd0, 12'd9, 32'hCAFE_0001, 1);
    issue(1'b1, 2'd0, 12'd10, 32'hCAFE_0002, 0);
    issue(1'b1, 2'd1, 12'd12, 32'h1234_5678, 20);
    issue(1'b0, 2'd3, 12'd13, 32'h0, 1);
    drain();

    // directed: host stalls the response for 5 cycles
    stall_req = 1'b1;
    issue(1'b0, 2'd0, 12'd5, 32'h0, 3);
    drain();
    stall_req = 1'b0;
    if (!stalled) flag("stall_not_exercised");

    // random traffic
    for (int i = 0; i < 150; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 6));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            vid_tab[$urandom_range(0, 6)], $urandom(), d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    // reset pulsed during ISSUE: transfer dropped, no response
    mon_en = 1'b0;
    dly_q.push_back(30);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_mid   = 2'd0;
    cmd_vid   = 12'd16;
    cmd_data  = 32'h0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!cmd_ready && guard < 300);
    if (!cmd_ready) flag("rst_cmd_accept_timeout");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_m_read", 32'(m_read), 32'(1));
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_m_read", 32'(m_read), 32'(0));
    chk("rst_m_write", 32'(m_write), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_m_address", 32'(m_address), 32'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_back_to_idle", 32'(cmd_ready), 32'(1));
    repeat (20) begin
      @(negedge clk);
      chk("rst_no_response", 32'(rsp_valid), 32'(0));
    end

    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'(0));
    chk("xfer_queue_empty", 32'(xfer_q.size()), 32'(0));
    chk("slave_write_edges", 32'(wr_edges), 32'(writes_issued));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
